// File: rtl/io_responder_pkg.sv
// Shared definitions for the CPU-bus IO responder: bus widths, default
// window placement and the responder FSM state type.
package io_responder_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int REG_WIDTH  = 8;

    localparam logic [15:0] IO_BASE_ADDR    = 16'h4000;
    localparam int          IO_NUM_REGS     = 16;
    localparam int          IO_WAIT_STATES  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } io_resp_state_t;

endpackage

// File: rtl/io_regfile.sv
// Register file behind the IO responder: CPU and host write ports (the CPU
// wins when both hit the same index), one registered read port that feeds
// the CPU data bus and one combinational host read port.
module io_regfile
    import io_responder_pkg::*;
#(
    parameter int NUM_REGS  = io_responder_pkg::IO_NUM_REGS,
    parameter int REG_WIDTH = io_responder_pkg::REG_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cpu_we,
    input  logic [$clog2(NUM_REGS)-1:0] cpu_idx,
    input  logic [REG_WIDTH-1:0]        cpu_wdata,
    input  logic                        host_we,
    input  logic [$clog2(NUM_REGS)-1:0] host_idx,
    input  logic [REG_WIDTH-1:0]        host_wdata,
    input  logic                        rd_en,
    input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
    output logic [REG_WIDTH-1:0]        rd_data,
    output logic [REG_WIDTH-1:0]        host_rdata
);

    logic [REG_WIDTH-1:0] regs_r [NUM_REGS];
    logic [REG_WIDTH-1:0] rd_data_r;

    // Storage update; the CPU assignment comes last so it overrides a host
    // write to the same index on the same edge. The read port samples the
    // pre-edge contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
            rd_data_r <= '0;
        end else begin
            if (host_we) begin
                regs_r[host_idx] <= host_wdata;
            end
            if (cpu_we) begin
                regs_r[cpu_idx] <= cpu_wdata;
            end
            if (rd_en) begin
                rd_data_r <= regs_r[rd_idx];
            end
        end
    end

    assign rd_data    = rd_data_r;
    assign host_rdata = regs_r[host_idx];

endmodule

// File: rtl/io_responder.sv
// Memory-mapped responder on the 6502 bus: decodes an aligned address window,
// serves reads from a register file after a fixed number of wait states
// (stalling the CPU through rdy) and commits writes immediately.
module io_responder
    import io_responder_pkg::*;
#(
    parameter int                                        ADDR_WIDTH  = io_responder_pkg::ADDR_WIDTH,
    parameter int                                        REG_WIDTH   = io_responder_pkg::REG_WIDTH,
    parameter logic [io_responder_pkg::ADDR_WIDTH-1:0]   BASE_ADDR   = io_responder_pkg::IO_BASE_ADDR,
    parameter int                                        NUM_REGS    = io_responder_pkg::IO_NUM_REGS,
    parameter int                                        WAIT_STATES = io_responder_pkg::IO_WAIT_STATES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        valid,
    input  logic [ADDR_WIDTH-1:0]       addr,
    input  logic                        r_w_n,
    input  logic [REG_WIDTH-1:0]        din,
    output logic [REG_WIDTH-1:0]        dout,
    output logic                        dout_oe,
    output logic                        rdy,
    input  logic                        host_we,
    input  logic [$clog2(NUM_REGS)-1:0] host_addr,
    input  logic [REG_WIDTH-1:0]        host_wdata,
    output logic [REG_WIDTH-1:0]        host_rdata,
    output logic                        cpu_wr,
    output logic [$clog2(NUM_REGS)-1:0] cpu_wr_idx
);

    localparam int         IDX_W   = $clog2(NUM_REGS);
    // Counter preload so that WAIT lasts exactly WAIT_STATES cycles.
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    io_resp_state_t    state_r, state_nx;
    logic [3:0]        ws_cnt_r, ws_cnt_nx;
    logic [IDX_W-1:0]  lat_idx_r, lat_idx_nx;
    logic              rdy_r, rdy_nx;
    logic              dout_oe_r, dout_oe_nx;
    logic              wr_pend_r;
    logic [IDX_W-1:0]  wr_pend_idx_r;
    logic              cpu_wr_r;
    logic [IDX_W-1:0]  cpu_wr_idx_r;

    logic              hit_s;
    logic [IDX_W-1:0]  req_idx_s;
    logic              cpu_we_s;
    logic              rd_en_s;
    logic [IDX_W-1:0]  rd_idx_s;

    assign req_idx_s = addr[IDX_W-1:0];
    assign hit_s     = valid && (addr[ADDR_WIDTH-1:IDX_W] == BASE_ADDR[ADDR_WIDTH-1:IDX_W]);

    // FSM, wait counter, latched index and registered bus handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            ws_cnt_r  <= 4'd0;
            lat_idx_r <= '0;
            rdy_r     <= 1'b1;
            dout_oe_r <= 1'b0;
        end else begin
            state_r   <= state_nx;
            ws_cnt_r  <= ws_cnt_nx;
            lat_idx_r <= lat_idx_nx;
            rdy_r     <= rdy_nx;
            dout_oe_r <= dout_oe_nx;
        end
    end

    // Next-state decode: requests are taken in IDLE and ACK only; WAIT
    // ignores the bus because the stalled CPU keeps it frozen.
    always_comb begin
        state_nx   = state_r;
        ws_cnt_nx  = ws_cnt_r;
        lat_idx_nx = lat_idx_r;
        rdy_nx     = 1'b1;
        dout_oe_nx = 1'b0;
        cpu_we_s   = 1'b0;
        rd_en_s    = 1'b0;
        rd_idx_s   = lat_idx_r;
        case (state_r)
            ST_IDLE, ST_ACK: begin
                if (hit_s && r_w_n) begin
                    lat_idx_nx = req_idx_s;
                    if (WAIT_STATES == 0) begin
                        state_nx   = ST_ACK;
                        rd_en_s    = 1'b1;
                        rd_idx_s   = req_idx_s;
                        dout_oe_nx = 1'b1;
                    end else begin
                        state_nx  = ST_WAIT;
                        ws_cnt_nx = WS_LOAD;
                        rdy_nx    = 1'b0;
                    end
                end else if (hit_s) begin
                    cpu_we_s = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (ws_cnt_r == 4'd0) begin
                    state_nx   = ST_ACK;
                    rd_en_s    = 1'b1;
                    dout_oe_nx = 1'b1;
                end else begin
                    ws_cnt_nx = ws_cnt_r - 4'd1;
                    rdy_nx    = 1'b0;
                end
            end
            default: begin
                state_nx  = ST_IDLE;
                ws_cnt_nx = 4'd0;
            end
        endcase
    end

    // Write-commit strobe: flagged at the committing edge, presented on
    // cpu_wr one cycle later; the index holds between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_pend_r     <= 1'b0;
            wr_pend_idx_r <= '0;
            cpu_wr_r      <= 1'b0;
            cpu_wr_idx_r  <= '0;
        end else begin
            wr_pend_r <= cpu_we_s;
            if (cpu_we_s) begin
                wr_pend_idx_r <= req_idx_s;
            end
            cpu_wr_r <= wr_pend_r;
            if (wr_pend_r) begin
                cpu_wr_idx_r <= wr_pend_idx_r;
            end
        end
    end

    io_regfile #(
        .NUM_REGS  (NUM_REGS),
        .REG_WIDTH (REG_WIDTH)
    ) u_regfile (
        .clk        (clk),
        .reset      (reset),
        .cpu_we     (cpu_we_s),
        .cpu_idx    (req_idx_s),
        .cpu_wdata  (din),
        .host_we    (host_we),
        .host_idx   (host_addr),
        .host_wdata (host_wdata),
        .rd_en      (rd_en_s),
        .rd_idx     (rd_idx_s),
        .rd_data    (dout),
        .host_rdata (host_rdata)
    );

    assign rdy        = rdy_r;
    assign dout_oe    = dout_oe_r;
    assign cpu_wr     = cpu_wr_r;
    assign cpu_wr_idx = cpu_wr_idx_r;

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: two instances (2 and 0 wait states) driven by
// directed steps then random transactions, checked against a register-array
// model and per-cycle timing derived from the wait-state count.
module tb_io_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        valid      [2];
    logic [15:0] addr       [2];
    logic        r_w_n      [2];
    logic [7:0]  din        [2];
    logic [7:0]  dout       [2];
    logic        dout_oe    [2];
    logic        rdy        [2];
    logic        host_we    [2];
    logic [3:0]  host_addr  [2];
    logic [7:0]  host_wdata [2];
    logic [7:0]  host_rdata [2];
    logic        cpu_wr     [2];
    logic [3:0]  cpu_wr_idx [2];

    int tests = 0;
    int fails = 0;

    logic [7:0] mdl [2][16];
    int         last_idx [2];
    int         ws_of [2];

    io_responder #(.WAIT_STATES(2)) dut_ws2 (
        .clk(clk), .reset(reset), .valid(valid[0]), .addr(addr[0]), .r_w_n(r_w_n[0]),
        .din(din[0]), .dout(dout[0]), .dout_oe(dout_oe[0]), .rdy(rdy[0]),
        .host_we(host_we[0]), .host_addr(host_addr[0]), .host_wdata(host_wdata[0]),
        .host_rdata(host_rdata[0]), .cpu_wr(cpu_wr[0]), .cpu_wr_idx(cpu_wr_idx[0])
    );

    io_responder #(.WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .reset(reset), .valid(valid[1]), .addr(addr[1]), .r_w_n(r_w_n[1]),
        .din(din[1]), .dout(dout[1]), .dout_oe(dout_oe[1]), .rdy(rdy[1]),
        .host_we(host_we[1]), .host_addr(host_addr[1]), .host_wdata(host_wdata[1]),
        .host_rdata(host_rdata[1]), .cpu_wr(cpu_wr[1]), .cpu_wr_idx(cpu_wr_idx[1])
    );

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    function automatic bit is_hit(input logic [15:0] a);
        return a[15:4] == 12'h400;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) mdl[d][i] = 8'h00;
            last_idx[d] = 0;
        end
    endtask

    task automatic host_write(input int d, input int idx, input logic [7:0] v);
        @(negedge clk);
        host_we[d] = 1'b1; host_addr[d] = 4'(idx); host_wdata[d] = v;
        @(negedge clk);
        host_we[d] = 1'b0;
        mdl[d][idx] = v;
    endtask

    task automatic check_reg(input int d, input int idx);
        @(negedge clk);
        host_addr[d] = 4'(idx);
        #1;
        chk("host_rdata", d, 32'(host_rdata[d]), 32'(mdl[d][idx]));
    endtask

    // One CPU read; optional host write to the same index one cycle after acceptance.
    task automatic cpu_read(input int d, input logic [15:0] a, input bit hw_en, input logic [7:0] hw_val);
        int ws;
        bit h;
        int idx;
        ws  = ws_of[d];
        h   = is_hit(a);
        idx = int'(a[3:0]);
        for (int k = 0; k <= ws + 1; k++) begin
            @(negedge clk);
            valid[d] = (k <= ws); addr[d] = a; r_w_n[d] = 1'b1;
            host_we[d] = hw_en && (k == 1);
            if (hw_en && k == 1) begin
                host_addr[d] = 4'(idx); host_wdata[d] = hw_val; mdl[d][idx] = hw_val;
            end
            @(posedge clk); #1;
            if (h && k < ws) begin
                chk("rd_wait_rdy", d, 32'(rdy[d]), 32'd0);
                chk("rd_wait_oe", d, 32'(dout_oe[d]), 32'd0);
            end else if (h && k == ws) begin
                chk("rd_ack_rdy", d, 32'(rdy[d]), 32'd1);
                chk("rd_ack_oe", d, 32'(dout_oe[d]), 32'd1);
                chk("rd_ack_dout", d, 32'(dout[d]), 32'(mdl[d][idx]));
            end else begin
                chk("rd_idle_rdy", d, 32'(rdy[d]), 32'd1);
                chk("rd_idle_oe", d, 32'(dout_oe[d]), 32'd0);
            end
        end
        host_we[d] = 1'b0;
    endtask

    task automatic cpu_write(input int d, input logic [15:0] a, input logic [7:0] v);
        bit h;
        h = is_hit(a);
        @(negedge clk);
        valid[d] = 1'b1; addr[d] = a; r_w_n[d] = 1'b0; din[d] = v;
        @(posedge clk); #1;
        if (h) begin
            mdl[d][int'(a[3:0])] = v;
            last_idx[d] = int'(a[3:0]);
        end
        chk("wr_e0_rdy", d, 32'(rdy[d]), 32'd1);
        chk("wr_e0_oe", d, 32'(dout_oe[d]), 32'd0);
        chk("wr_e0_strobe", d, 32'(cpu_wr[d]), 32'd0);
        @(negedge clk);
        valid[d] = 1'b0;
        @(posedge clk); #1;
        chk("wr_e1_rdy", d, 32'(rdy[d]), 32'd1);
        chk("wr_e1_strobe", d, 32'(cpu_wr[d]), 32'(h));
        chk("wr_e1_idx", d, 32'(cpu_wr_idx[d]), 32'(last_idx[d]));
        @(posedge clk); #1;
        chk("wr_e2_strobe", d, 32'(cpu_wr[d]), 32'd0);
        chk("wr_e2_rdy", d, 32'(rdy[d]), 32'd1);
    endtask

    // Safety net so a stuck design can never hang the run.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        int d, op, idx;
        logic [15:0] a;
        logic [7:0]  v;

        ws_of[0] = 2;
        ws_of[1] = 0;
        clear_model();
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0; addr[i] = 16'h0000; r_w_n[i] = 1'b1; din[i] = 8'h00;
            host_we[i] = 1'b0; host_addr[i] = 4'd0; host_wdata[i] = 8'h00;
        end
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_rdy", i, 32'(rdy[i]), 32'd1);
            chk("rst_oe", i, 32'(dout_oe[i]), 32'd0);
            chk("rst_dout", i, 32'(dout[i]), 32'd0);
            chk("rst_cpu_wr", i, 32'(cpu_wr[i]), 32'd0);
            chk("rst_cpu_wr_idx", i, 32'(cpu_wr_idx[i]), 32'd0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Host write then CPU read with two wait states.
        host_write(0, 3, 8'hA5);
        cpu_read(0, 16'h4003, 1'b0, 8'h00);

        // CPU write to the top register of the window.
        cpu_write(0, 16'h400F, 8'h3C);
        check_reg(0, 15);

        // Misses on both sides of the window.
        cpu_read(0, 16'h4010, 1'b0, 8'h00);
        cpu_read(0, 16'h3FFF, 1'b0, 8'h00);
        cpu_write(0, 16'h4010, 8'hFF);
        cpu_write(0, 16'h3FFF, 8'hEE);
        check_reg(0, 3);
        check_reg(0, 15);
        check_reg(0, 0);

        // Same-edge host and CPU write to index 5: CPU value must stick.
        @(negedge clk);
        host_we[0] = 1'b1; host_addr[0] = 4'd5; host_wdata[0] = 8'h11;
        valid[0] = 1'b1; addr[0] = 16'h4005; r_w_n[0] = 1'b0; din[0] = 8'h22;
        @(negedge clk);
        host_we[0] = 1'b0; valid[0] = 1'b0;
        mdl[0][5] = 8'h22;
        last_idx[0] = 5;
        @(negedge clk);
        host_addr[0] = 4'd5;
        #1;
        chk("coll_reg", 0, 32'(host_rdata[0]), 32'h22);
        chk("coll_strobe", 0, 32'(cpu_wr[0]), 32'd1);
        chk("coll_idx", 0, 32'(cpu_wr_idx[0]), 32'd5);
        @(negedge clk); #1;
        chk("coll_strobe_end", 0, 32'(cpu_wr[0]), 32'd0);

        // Host write to the latched index while the read is waiting.
        host_write(0, 7, 8'h01);
        cpu_read(0, 16'h4007, 1'b1, 8'h77);

        // Zero wait states: four back-to-back reads of idx 0..3.
        for (int i = 0; i < 4; i++) host_write(1, i, 8'($urandom));
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            valid[1] = (k < 4); addr[1] = 16'h4000 + 16'(k); r_w_n[1] = 1'b1;
            @(posedge clk); #1;
            chk("b2b_rdy", 1, 32'(rdy[1]), 32'd1);
            if (k < 4) begin
                chk("b2b_oe", 1, 32'(dout_oe[1]), 32'd1);
                chk("b2b_dout", 1, 32'(dout[1]), 32'(mdl[1][k]));
            end else begin
                chk("b2b_oe_end", 1, 32'(dout_oe[1]), 32'd0);
            end
        end
        cpu_write(1, 16'h4009, 8'h5A);
        cpu_read(1, 16'h4009, 1'b0, 8'h00);

        // Reset in the middle of a waiting read.
        @(negedge clk);
        valid[0] = 1'b1; addr[0] = 16'h4003; r_w_n[0] = 1'b1;
        @(posedge clk); #1;
        chk("mid_rdy_low", 0, 32'(rdy[0]), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_rdy", 0, 32'(rdy[0]), 32'd1);
        chk("mid_rst_oe", 0, 32'(dout_oe[0]), 32'd0);
        chk("mid_rst_dout", 0, 32'(dout[0]), 32'd0);
        @(negedge clk);
        valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("post_rst_oe", 0, 32'(dout_oe[0]), 32'd0);
            chk("post_rst_rdy", 0, 32'(rdy[0]), 32'd1);
        end
        for (int i = 0; i < 16; i++) check_reg(0, i);
        check_reg(1, 0);
        check_reg(1, 9);

        // Random transactions against the model.
        for (int n = 0; n < 300; n++) begin
            d   = int'($urandom % 2);
            op  = int'($urandom % 4);
            idx = int'($urandom % 16);
            v   = 8'($urandom);
            if ($urandom % 4 != 0) a = 16'h4000 | 16'(idx);
            else a = 16'($urandom);
            case (op)
                0: host_write(d, idx, v);
                1: cpu_write(d, a, v);
                2: cpu_read(d, a, (d == 0) && is_hit(a) && ($urandom % 3 == 0), v);
                default: check_reg(d, idx);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
